// File: rtl/rvvi_flow_control.sv
// Applies host acknowledgements to the RVVI trace-out path: enforces the inter-frame gap
// on the outgoing packetizer and stalls the core when too many instructions are unacknowledged.
module rvvi_flow_control #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned WINDOW        = 1024,
  parameter logic [31:0] DEFAULT_DELAY = 32'd16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Valid,
  input  logic [XLEN-1:0] Minstr,
  input  logic [31:0]     InterPacketDelay,
  input  logic [XLEN-1:0] LocalMinstret,
  input  logic            FrameStart,
  input  logic            FrameEnd,
  output logic            FrameGo,
  output logic            HostStall,
  output logic [XLEN-1:0] AckMinstret,
  output logic            ProtoErr
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SENDING,
    ST_GAP
  } state_e;

  state_e          state_q;
  logic [31:0]     gap_cnt_q;
  logic [31:0]     delay_q, delay_d;
  logic [XLEN-1:0] ack_q, ack_d;
  logic            stall_q, stall_d;
  logic            proto_err_q;
  logic [XLEN-1:0] outstanding;

  // Unsigned subtraction: a wrapped retire counter still yields the true distance.
  assign outstanding = LocalMinstret - ack_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    ack_d   = ack_q;
    delay_d = delay_q;
    stall_d = (outstanding >= XLEN'(WINDOW));
    if (Valid && (Minstr >= ack_q)) begin
      ack_d   = Minstr;
      delay_d = InterPacketDelay;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together
  // from pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q   <= '0;
      delay_q <= DEFAULT_DELAY;
      stall_q <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      delay_q <= delay_d;
      stall_q <= stall_d;
    end
  end

  // The gap length is taken from delay_q at the FrameEnd edge; a simultaneous ack only
  // affects the following frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gap_cnt_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (FrameStart && (state_q != ST_IDLE)) begin
        proto_err_q <= 1'b1;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (FrameStart) begin
            if (!FrameEnd) begin
              state_q <= ST_SENDING;
            end else if (delay_q != 32'd0) begin
              state_q   <= ST_GAP;
              gap_cnt_q <= delay_q;
            end
          end
        end
        ST_SENDING: begin
          if (FrameEnd) begin
            if (delay_q != 32'd0) begin
              state_q   <= ST_GAP;
              gap_cnt_q <= delay_q;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          gap_cnt_q <= gap_cnt_q - 32'd1;
          if (gap_cnt_q <= 32'd1) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign FrameGo     = (state_q == ST_IDLE);
  assign HostStall   = stall_q;
  assign AckMinstret = ack_q;
  assign ProtoErr    = proto_err_q;

endmodule
